ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-port arbiter and sequencer in front of the dual-SRAM ram_full controller. It accepts read/write requests from two requesters: port 0 is the CPU/instruction side, port 1 is the UART/loader side. It grants one request at a time and drives ram_full's en/re/we/addr/data_in. It waits for ram_full's done and returns read data with a one-cycle ack to the granted port. addr[16] is passed through unchanged and selects RAM1 or RAM2 inside ram_full.

Parameters:
ADDR_W, 17, request/RAM address width (MSB = chip select).
DATA_W, 16, data width.
TIMEOUT, 255, max ACCESS cycles waiting for ram_done before abort; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-high.
req0  in  1  port 0 request; held high until ack0.
we0  in  1  port 0 op: 1 = write, 0 = read.
addr0  in  ADDR_W  port 0 address.
wdata0  in  DATA_W  port 0 write data.
req1/we1/addr1/wdata1  in  1/1/ADDR_W/DATA_W  port 1 equivalents.
ack0  out  1  one-cycle completion pulse for port 0.
ack1  out  1  one-cycle completion pulse for port 1.
rdata  out  DATA_W  read data; valid in the ack cycle, held until the next ack.
err  out  1  high in an ack cycle if that access timed out.
busy  out  1  high whenever the state is not IDLE.
ram_en  out  1  to ram_full en.
ram_re  out  1  to ram_full re.
ram_we  out  1  to ram_full we.
ram_addr  out  ADDR_W  to ram_full addr.
ram_din  out  DATA_W  to ram_full data_in.
ram_dout  in  DATA_W  from ram_full data_out.
ram_done  in  1  from ram_full done.

Behaviour:
- All outputs are registered.
- Reset values: ack0=ack1=err=busy=0; ram_en=ram_re=ram_we=0; ram_addr=0; ram_din=0; rdata=0; state IDLE; rr pointer=0; timeout counter=0.
- States: IDLE, ACCESS, RELEASE.
- IDLE:
  - If no req, stay in IDLE with ram_en=0.
  - If any req, pick a winner, latch grant id, addr, wdata and we, then go to ACCESS.
  - Next cycle: ram_en=1, ram_we=we, ram_re=~we; ram_re and ram_we are never both high.
- ACCESS:
  - Hold ram_* stable. The counter increments each cycle.
  - On ram_done=1: capture ram_dout into rdata (reads only; writes leave rdata unchanged), then go to RELEASE.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with no done: go to RELEASE with the error flag set.
- RELEASE (exactly 1 cycle):
  - ram_re=ram_we=0, ram_en stays 1 so ram_full returns idle.
  - ack of the granted port = 1; err = timeout flag.
  - Toggle the rr pointer, then go to IDLE.
- Latency: req sampled in IDLE at cycle 0 → ram_re/ram_we high from cycle 1. If ram_done is first seen in cycle k (k≥1), ack is in cycle k+1. Back-to-back requests issue again 1 cycle after ack (IDLE cycle in between).
- Requester rule: req may drop only after ack. Request inputs are ignored outside IDLE; latched values are used.
- Simultaneous req0 and req1: resolved by arbitration policy (see Optional Feature). The loser waits and is granted in the next IDLE if still requesting.
- ram_done high on entry to ACCESS: accepted in the first ACCESS cycle.
- ram_done in IDLE or RELEASE: ignored.
- Reset mid-operation: immediate return to reset values, ram_we drops asynchronously, no ack issued.
- Timed-out read: rdata is not updated.

Optional Feature:
- Macro RAM_ARB_RR_EN.
- Defined: round-robin. On contention, the port ≠ last-granted wins; the rr pointer updates in RELEASE.
- Undefined: fixed priority, port 0 always wins; the rr pointer is not implemented.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Port 0 write addr=17'h00005, wdata=16'h000E; RAM model raises done 3 cycles after we → ram_we high cycles 1–3, ack0 in cycle 4, err=0, ack1 never.
- Port 1 read addr=17'h10005 after that write; model returns 16'h000E → ram_addr[16]=1, ram_re=1, ram_we=0, rdata=16'h000E in the ack1 cycle.
- req0 and req1 both high from the same cycle, reads with model data 16'h1111 / 16'h2222:
  - With RAM_ARB_RR_EN: order is port0, port1, then port0 again on repeat.
  - Without the macro: port0 is served repeatedly while req0 stays high.
- TIMEOUT=8, model never asserts done → ack0 with err=1 in cycle 10; rdata unchanged; then IDLE.
- Assert rst in ACCESS during a write → ram_we=0 and busy=0 immediately; no ack; a new req after reset is served normally.
- Done asserted combinationally in the first ACCESS cycle → ack in cycle 2 from req; busy high for exactly cycles 1–2.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port arbiter/sequencer in front of the ram_full dual-SRAM controller.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module ram_arbiter #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  input  logic              ram_done
);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t             state, state_nx;
  logic               grant, grant_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               ack0_nx, ack1_nx, err_nx, busy_nx;
  logic               ram_en_nx, ram_re_nx, ram_we_nx;
  logic [ADDR_W-1:0]  ram_addr_nx;
  logic [DATA_W-1:0]  ram_din_nx, rdata_nx;
  logic               pick1;

`ifdef RAM_ARB_RR_EN
  // rr_ptr names the port that wins the next contended IDLE cycle.
  logic rr_ptr, rr_nx;
  assign pick1 = req1 & (~req0 | rr_ptr);
`else
  assign pick1 = req1 & ~req0;
`endif

  // NOTE: every next-value signal gets a default first so no latch is inferred
  // for paths that do not assign it.
  always_comb begin
    state_nx    = state;
    grant_nx    = grant;
    cnt_nx      = cnt;
    ack0_nx     = 1'b0;
    ack1_nx     = 1'b0;
    err_nx      = 1'b0;
    ram_en_nx   = ram_en;
    ram_re_nx   = ram_re;
    ram_we_nx   = ram_we;
    ram_addr_nx = ram_addr;
    ram_din_nx  = ram_din;
    rdata_nx    = rdata;
`ifdef RAM_ARB_RR_EN
    rr_nx       = rr_ptr;
`endif

    unique case (state)
      IDLE: begin
        ram_en_nx = 1'b0;
        ram_re_nx = 1'b0;
        ram_we_nx = 1'b0;
        if (req0 || req1) begin
          grant_nx    = pick1;
          ram_addr_nx = pick1 ? addr1  : addr0;
          ram_din_nx  = pick1 ? wdata1 : wdata0;
          ram_we_nx   = pick1 ? we1    : we0;
          ram_re_nx   = ~(pick1 ? we1 : we0);
          ram_en_nx   = 1'b1;
          cnt_nx      = '0;
          state_nx    = ACCESS;
        end
      end

      ACCESS: begin
        cnt_nx = cnt + CNT_W'(1);
        // ram_we still carries the latched op, so it selects read capture.
        if (ram_done) begin
          if (!ram_we) rdata_nx = ram_dout;
          state_nx = RELEASE;
        end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT))) begin
          err_nx   = 1'b1;
          state_nx = RELEASE;
        end
        if (state_nx == RELEASE) begin
          ack0_nx   = ~grant;
          ack1_nx   = grant;
          ram_re_nx = 1'b0;
          ram_we_nx = 1'b0;
        end
      end

      RELEASE: begin
        ram_en_nx = 1'b0;
        state_nx  = IDLE;
`ifdef RAM_ARB_RR_EN
        rr_nx     = ~grant;
`endif
      end

      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= 1'b0;
      cnt      <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      ram_en   <= 1'b0;
      ram_re   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rdata    <= '0;
`ifdef RAM_ARB_RR_EN
      rr_ptr   <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      grant    <= grant_nx;
      cnt      <= cnt_nx;
      ack0     <= ack0_nx;
      ack1     <= ack1_nx;
      err      <= err_nx;
      busy     <= busy_nx;
      ram_en   <= ram_en_nx;
      ram_re   <= ram_re_nx;
      ram_we   <= ram_we_nx;
      ram_addr <= ram_addr_nx;
      ram_din  <= ram_din_nx;
      rdata    <= rdata_nx;
`ifdef RAM_ARB_RR_EN
      rr_ptr   <= rr_nx;
`endif
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: table of single-port transactions against a
// small ram_full model, plus contention, timeout and mid-access reset sequences.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [16:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, err, busy;
  logic        ram_en, ram_re, ram_we, ram_done;
  logic [16:0] ram_addr;
  logic [15:0] ram_din, ram_dout, rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(17), .DATA_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
    .ram_en(ram_en), .ram_re(ram_re), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .ram_done(ram_done)
  );

  // ram_full model: done after model_delay active cycles (0 = combinational).
  logic [7:0]  model_delay;
  logic [7:0]  acc_cnt;
  logic [15:0] mem [0:2047];
  logic [10:0] midx;
  logic        active;

  assign midx     = {ram_addr[16], ram_addr[9:0]};
  assign active   = ram_en & (ram_re | ram_we);
  assign ram_done = active && (acc_cnt == model_delay);
  assign ram_dout = mem[midx];

  always @(posedge clk) begin
    if (rst) begin
      acc_cnt <= 8'd0;
      mem[{1'b1, 10'h005}] <= 16'h000E;
      mem[{1'b0, 10'h100}] <= 16'h1111;
      mem[{1'b1, 10'h300}] <= 16'h2222;
    end else begin
      acc_cnt <= active ? acc_cnt + 8'd1 : 8'd0;
      if (ram_done && ram_we) mem[midx] <= ram_din;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [16:0] addr;
    logic [15:0] wdata;
    logic [7:0]  delay;
    logic [15:0] rd;
    logic        err;
    int          ack_cyc;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] last_rdata = 16'h0000;

  // Cycle 0 is the IDLE cycle in which the request is first sampled.
  task automatic run_txn(input vec_t v);
    int          ack_at;
    logic [15:0] exp_rd;
    ack_at = 0;
    exp_rd = (!v.we && !v.err) ? v.rd : last_rdata;
    @(negedge clk);
    model_delay = v.delay;
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    for (int c = 1; c <= 30 && ack_at == 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) begin
        check("issue_en",   ram_en,   1);
        check("issue_we",   ram_we,   v.we);
        check("issue_re",   ram_re,   !v.we);
        check("issue_addr", ram_addr, v.addr);
        check("issue_busy", busy,     1);
        if (v.we) check("issue_din", ram_din, v.wdata);
      end
      check("other_ack", v.port ? ack0 : ack1, 0);
      if (v.port ? ack1 : ack0) begin
        ack_at = c;
        check("ack_err",   err,   v.err);
        check("ack_rdata", rdata, exp_rd);
        check("ack_busy",  busy,  1);
        check("ack_rewe",  {ram_re, ram_we}, 2'b00);
        if (v.port) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    check("ack_cycle", ack_at, v.ack_cyc);
    last_rdata = exp_rd;
    @(posedge clk); @(negedge clk);
    check("post_ack", {ack0, ack1, busy, ram_en}, 4'b0000);
  endtask

  initial begin
    int n;
    int got;
    int exp_g[3];
    vec_t v;

    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    model_delay = 8'd0;

    //         port  we    addr       wdata     dly    rd        err   ack
    vecs[0] = '{1'b0, 1'b1, 17'h00005, 16'h000E, 8'd2,   16'h0000, 1'b0, 4};
    vecs[1] = '{1'b1, 1'b0, 17'h10005, 16'h0000, 8'd2,   16'h000E, 1'b0, 4};
    vecs[2] = '{1'b0, 1'b0, 17'h00005, 16'h0000, 8'd0,   16'h000E, 1'b0, 2};
    vecs[3] = '{1'b0, 1'b0, 17'h00100, 16'h0000, 8'd8,   16'h1111, 1'b0, 10};
    vecs[4] = '{1'b1, 1'b1, 17'h10200, 16'h1234, 8'd5,   16'h0000, 1'b0, 7};
    vecs[5] = '{1'b1, 1'b0, 17'h10200, 16'h0000, 8'd1,   16'h1234, 1'b0, 3};
    vecs[6] = '{1'b0, 1'b0, 17'h00100, 16'h0000, 8'd255, 16'h0000, 1'b1, 10};
    vecs[7] = '{1'b1, 1'b1, 17'h10005, 16'h5555, 8'd255, 16'h0000, 1'b1, 10};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {ack0, ack1, err, busy, ram_en, ram_re, ram_we}, 7'd0);
    check("reset_addr", ram_addr, 0);
    check("reset_din",  ram_din,  0);
    check("reset_rdata", rdata,   0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Contention: both ports read and keep requesting after each ack.
`ifdef RAM_ARB_RR_EN
    exp_g = '{0, 1, 0};
`else
    exp_g = '{0, 0, 0};
`endif
    @(negedge clk);
    model_delay = 8'd1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 17'h00100;
    req1 = 1'b1; we1 = 1'b0; addr1 = 17'h10300;
    n = 0;
    for (int c = 0; c < 200 && n < 3; c++) begin
      @(posedge clk); @(negedge clk);
      if (ack0 || ack1) begin
        check("contend_port", ack1, exp_g[n]);
        check("contend_rdata", rdata, ack1 ? 16'h2222 : 16'h1111);
        n++;
      end
    end
    check("contend_grants", n, 3);
    req0 = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && got == 0; c++) begin
      @(posedge clk); @(negedge clk);
      check("loser_no_ack0", ack0, 0);
      if (ack1) begin
        got = 1;
        check("loser_rdata", rdata, 16'h2222);
      end
    end
    check("loser_served", got, 1);
    req1 = 1'b0;
    last_rdata = 16'h2222;
    repeat (2) @(posedge clk);

    // Reset asserted while a write is in ACCESS.
    @(negedge clk);
    model_delay = 8'd255;
    req0 = 1'b1; we0 = 1'b1; addr0 = 17'h00100; wdata0 = 16'hBEEF;
    @(posedge clk); @(negedge clk);
    check("rst_pre_we", ram_we, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_async", {ram_we, busy, ram_en}, 3'b000);
    @(negedge clk);
    req0 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      check("rst_no_ack", {ack0, ack1}, 2'b00);
    end
    rst = 1'b0;
    last_rdata = 16'h0000;
    v = vecs[3];
    v.delay = 8'd2;
    v.ack_cyc = 4;
    run_txn(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
